// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction size and the PC alignment mask, plus an alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT_RESP = 2'd1,
        HOLD      = 2'd2,
        FAULT     = 2'd3
    } fetch_state_e;

    localparam int         INSTR_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    // True when the address is a legal instruction address (word aligned).
    function automatic logic is_aligned(input logic [31:0] addr);
        return ((addr[1:0] & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Owns the program counter and fetches one 32-bit instruction per PC over a
// valid/ready request channel with a variable-latency single-pulse response.
// The fetched word is held for decode; on decode accept the selector's
// next_pc is loaded into the PC, or a sticky fault is raised if it is not
// word aligned.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   next_pc         next PC from the branch/jump selector (used on accept)
//   instr_addr      current PC
//   mem_req_*       fetch request channel (valid/ready, address = PC)
//   mem_resp_*      fetch response (valid pulse + data)
//   instr_valid/ready, instr   instruction handoff to decode
//   fault, fault_addr          sticky misaligned-target fault and its address
//   instr_count     number of instructions accepted by decode (wraps)
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic [31:0] instr_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] instr_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_addr_q, fault_addr_d;
    logic         req_valid_q;
    logic         instr_valid_q;

    // Next-state and datapath update logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        count_d      = count_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            REQ: begin
                // Any response seen here is stray and deliberately ignored.
                if (mem_req_ready) begin
                    state_d = WAIT_RESP;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    instr_d = mem_resp_data;
                    state_d = HOLD;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    if (is_aligned(next_pc)) begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end else begin
                        // PC keeps the address of the instruction that branched badly.
                        fault_addr_d = next_pc;
                        fault_d      = 1'b1;
                        state_d      = FAULT;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_VECTOR;
            instr_q      <= 32'd0;
            count_q      <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            count_q      <= count_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Handshake outputs registered from the next state so they exactly track
    // the state register without a decode path on the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q   <= 1'b1;
            instr_valid_q <= 1'b0;
        end else begin
            req_valid_q   <= (state_d == REQ);
            instr_valid_q <= (state_d == HOLD);
        end
    end

    assign instr_addr    = pc_q;
    assign mem_req_addr  = pc_q;
    assign mem_req_valid = req_valid_q;
    assign instr_valid   = instr_valid_q;
    assign instr         = instr_q;
    assign fault         = fault_q;
    assign fault_addr    = fault_addr_q;
    assign instr_count   = count_q;

endmodule
